hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes the per-instruction decode controls (ValidReg, RegWrite, MemRead, MemWrite) at ID, plus the EX redirect and the data-memory ready handshake.
- Generates pipeline-register enables, flushes and registered forwarding selects.
- Keeps its own shadow of rd/control per downstream stage, so the datapath need not feed them back.

---
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stage enables,
// bubbles, registered forwarding selects and stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_valid_reg,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mw;
  } shadow_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state_r;
  shadow_t    ex_r;
  shadow_t    mem_r;
  shadow_t    id_s;
  logic       mem_busy_s;
  logic       load_use_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // EX is nearer than MEM, so it wins; a load in EX cannot forward yet.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] rs,
                                         input shadow_t ex, input shadow_t mem);
    logic [1:0] sel;
    if (use_src && ex.v && ex.rw && !ex.mr && (ex.rd == rs)) begin
      sel = 2'd1;
    end else if (use_src && mem.v && mem.rw && (mem.rd == rs)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Decode controls of the ID instruction, hazard detection and forward selects.
  always_comb begin
    id_s.v  = id_valid;
    id_s.rd = id_rd;
    id_s.rw = id_reg_write && id_valid_reg[0] && (id_rd != 5'd0);
    id_s.mr = id_mem_read;
    id_s.mw = id_mem_write;
    mem_busy_s = mem_r.v && (mem_r.mr || mem_r.mw) && !dmem_ready;
    load_use_s = ex_r.v && ex_r.mr && ex_r.rw && id_valid &&
                 ((id_valid_reg[1] && (id_rs1 == ex_r.rd)) ||
                  (id_valid_reg[2] && (id_rs2 == ex_r.rd)));
    fwd_a_s = fwd_sel(id_valid_reg[1], id_rs1, ex_r, mem_r);
    fwd_b_s = fwd_sel(id_valid_reg[2], id_rs2, ex_r, mem_r);
  end

  // Zero-latency enables and flushes: reset > freeze > redirect > load-use > normal.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    if (rst || mem_busy_s) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use_s) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // State, stage shadows, registered forward selects and counters.
  // Forwarding never looks at WB (register file writes before it reads), so no WB shadow is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      ex_r        <= '0;
      mem_r       <= '0;
      fwd_a       <= 2'd0;
      fwd_b       <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (mem_busy_s) begin
        state_r <= MEM_WAIT;
      end else if (load_use_s && !ex_redirect) begin
        state_r <= LU_STALL;
      end else begin
        state_r <= RUN;
      end
      if (!pc_en) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (!mem_busy_s) begin
        mem_r <= ex_r;
        if (idex_flush) begin
          ex_r  <= '0;
          fwd_a <= 2'd0;
          fwd_b <= 2'd0;
        end else begin
          ex_r  <= id_s;
          fwd_a <= fwd_a_s;
          fwd_b <= fwd_b_s;
        end
        if (ex_redirect) begin
          flush_count <= flush_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: forwarding, load-use, x0 and
// ValidReg masking, redirect, memory freeze and asynchronous reset.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_valid_reg;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        ex_redirect, dmem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count, flush_count;
  logic [6:0]  ctl;

  int total_cnt = 0;
  int bad_cnt = 0;

  localparam logic [6:0] CTL_OFF  = 7'b0000000;
  localparam logic [6:0] CTL_RUN  = 7'b1101011;
  localparam logic [6:0] CTL_RDIR = 7'b1111111;
  localparam logic [6:0] CTL_LU   = 7'b0001111;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_valid_reg(id_valid_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .ex_redirect(ex_redirect),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [2:0] vr, input logic rw,
                        input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_valid_reg = vr; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; dmem_ready = 1'b1;
    nop();
    #2;
    chk("rst_ctl", {25'd0, ctl}, {25'd0, CTL_OFF});
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});

    // Back-to-back: ADD x5,x1,x2 ; ADD x6,x5,x3
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 3'b111, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 5'd5, 5'd3, 5'd6, 3'b111, 1'b1, 1'b0, 1'b0); #1;
    chk("b2b_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});
    step();
    chk("b2b_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("b2b_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // Same pair with a NOP between: forward from MEM/WB
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 3'b111, 1'b1, 1'b0, 1'b0); step();
    nop(); step();
    set_id(1'b1, 5'd5, 5'd3, 5'd6, 3'b111, 1'b1, 1'b0, 1'b0); step();
    chk("gap_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("gap_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // Load-use: LW x7,0(x1) ; ADD x8,x7,x7
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 3'b011, 1'b1, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd7, 5'd7, 5'd8, 3'b111, 1'b1, 1'b0, 1'b0); #1;
    chk("lu_ctl", {25'd0, ctl}, {25'd0, CTL_LU});
    step();
    chk("lu_state", 32'(dut.state_r), 32'd1);
    chk("lu_stall_cnt", stall_count, 32'd1);
    chk("lu_bubble_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("lu_one_bubble", {25'd0, ctl}, {25'd0, CTL_RUN});
    step();
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd2);
    chk("lu_state_run", 32'(dut.state_r), 32'd0);
    drain();

    // x0: LW x0 ; ADD x1,x0,x0 -> no stall, no forward
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 3'b011, 1'b1, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd0, 5'd0, 5'd1, 3'b111, 1'b1, 1'b0, 1'b0); #1;
    chk("x0_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});
    step();
    chk("x0_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    drain();

    // ValidReg masking: LW x9 ; LUI x9 with rs fields aliasing x9
    set_id(1'b1, 5'd1, 5'd0, 5'd9, 3'b011, 1'b1, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd9, 5'd9, 5'd9, 3'b001, 1'b1, 1'b0, 1'b0); #1;
    chk("vr_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});
    step();
    chk("vr_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("vr_stall_cnt", stall_count, 32'd1);
    drain();

    // Redirect alone
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 3'b111, 1'b1, 1'b0, 1'b0);
    ex_redirect = 1'b1; #1;
    chk("rd_ctl", {25'd0, ctl}, {25'd0, CTL_RDIR});
    step();
    ex_redirect = 1'b0;
    chk("rd_flush_cnt", flush_count, 32'd1);
    drain();

    // Redirect coinciding with load-use: redirect wins
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 3'b011, 1'b1, 1'b1, 1'b0); step();
    set_id(1'b1, 5'd7, 5'd7, 5'd8, 3'b111, 1'b1, 1'b0, 1'b0);
    ex_redirect = 1'b1; #1;
    chk("rdlu_ctl", {25'd0, ctl}, {25'd0, CTL_RDIR});
    step();
    ex_redirect = 1'b0;
    chk("rdlu_stall_cnt", stall_count, 32'd1);
    chk("rdlu_flush_cnt", flush_count, 32'd2);
    chk("rdlu_state", 32'(dut.state_r), 32'd0);
    drain();

    // Memory wait: ADD x1 ; SW x2,0(x1) ; ADD x4,x1,x2 (fwd_a=2) ; SW stalls in MEM
    set_id(1'b1, 5'd0, 5'd0, 5'd1, 3'b111, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 3'b110, 1'b0, 1'b0, 1'b1); step();
    chk("mw_sw_fwd_a", {30'd0, fwd_a}, 32'd1);
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 3'b111, 1'b1, 1'b0, 1'b0); step();
    chk("mw_pre_fwd_a", {30'd0, fwd_a}, 32'd2);
    set_id(1'b1, 5'd4, 5'd4, 5'd5, 3'b111, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_redirect = (i == 1);
      #1;
      chk("mw_ctl", {25'd0, ctl}, {25'd0, CTL_OFF});
      step();
      chk("mw_state", 32'(dut.state_r), 32'd2);
      chk("mw_fwd_hold", {28'd0, fwd_a, fwd_b}, 32'h8);
    end
    ex_redirect = 1'b0;
    chk("mw_stall_cnt", stall_count, 32'd4);
    chk("mw_flush_ignored", flush_count, 32'd2);
    dmem_ready = 1'b1; #1;
    chk("mw_release_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});
    step();
    chk("mw_after_fwd", {28'd0, fwd_a, fwd_b}, 32'h5);
    chk("mw_after_state", 32'(dut.state_r), 32'd0);
    drain();

    // Asynchronous reset during MEM_WAIT
    set_id(1'b1, 5'd0, 5'd0, 5'd1, 3'b111, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 3'b110, 1'b0, 1'b0, 1'b1); step();
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 3'b111, 1'b1, 1'b0, 1'b0); step();
    dmem_ready = 1'b0; step();
    chk("ar_state_wait", 32'(dut.state_r), 32'd2);
    #2;
    rst = 1'b1; #1;
    chk("ar_ctl", {25'd0, ctl}, {25'd0, CTL_OFF});
    chk("ar_stall_cnt", stall_count, 32'd0);
    chk("ar_flush_cnt", flush_count, 32'd0);
    chk("ar_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("ar_shadow_v", {30'd0, dut.ex_r.v, dut.mem_r.v}, 32'd0);
    chk("ar_state", 32'(dut.state_r), 32'd0);
    nop(); dmem_ready = 1'b1;
    step();
    rst = 1'b0; #1;
    chk("ar_release_ctl", {25'd0, ctl}, {25'd0, CTL_RUN});
    step();
    chk("ar_release_state", 32'(dut.state_r), 32'd0);
    chk("ar_release_stall", stall_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
